// File: rtl/leg_uart_pkg.sv
// leg_uart_pkg: shared UART transmitter types and constants
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
package leg_uart_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} tx_state_t;
  localparam int UART_FRAME_BITS = 10;
  localparam int CLKS_PER_BIT_DEF = 434;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period down-counter producing a one-cycle tick per bit
module uart_baud_gen
  import leg_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  input  logic enable,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = enable && cnt_q == '0;
  // reload on request or at the end of every bit so each bit lasts CLKS_PER_BIT cycles
  always_comb cnt_d = (reload || tick) ? W'(CLKS_PER_BIT - 1) : enable ? cnt_q - 1'b1 : cnt_q;
  // counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a FIFO and sends them LSB byte first as 8N1 UART frames
module fifo_uart_tx
  import leg_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int BYTES_PER_WORD = `DATA_WIDTH / 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [`DATA_WIDTH-1:0] fifo_data_out,
  input  logic                   fifo_empty,
  output logic                   fifo_read_enabled,
  output logic                   tx,
  output logic                   busy,
  output logic [15:0]            words_sent
);
  if (`DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 8");
  end
  tx_state_t state_q, state_d;
  logic [`DATA_WIDTH-1:0] word_q, word_d;
  logic [7:0] byte_q, byte_d, cur_byte;
  logic [2:0] bit_q, bit_d, nb;
  logic tx_q, tx_d, rd_q, rd_d, busy_q, busy_d, tick, reload, enable;
  logic [15:0] words_sent_q, words_sent_d;
  assign fifo_read_enabled = rd_q;
  assign tx = tx_q;
  assign busy = busy_q;
  assign words_sent = words_sent_q;
  assign cur_byte = 8'(word_q >> {byte_q, 3'b000});
  assign nb = bit_q + 3'd1;
  assign reload = state_q == LOAD;
  assign enable = (state_q == START || state_q == DATA || state_q == STOP) && !rd_q;
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk), .rst_n(rst_n), .reload(reload), .enable(enable), .tick(tick)
  );
  // next-state logic; a cycle with rd_q high is the pop cycle and always leads to FETCH
  always_comb begin
    state_d = state_q;
    word_d = word_q;
    byte_d = byte_q;
    bit_d = bit_q;
    tx_d = tx_q;
    rd_d = 1'b0;
    busy_d = busy_q;
    words_sent_d = words_sent_q;
    if (rd_q) state_d = FETCH;
    else case (state_q)
      IDLE: if (!fifo_empty) begin
        rd_d = 1'b1;
        busy_d = 1'b1;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        word_d = fifo_data_out;
        byte_d = '0;
        bit_d = '0;
        tx_d = 1'b0;
        state_d = START;
      end
      START: if (tick) begin
        tx_d = cur_byte[0];
        bit_d = '0;
        state_d = DATA;
      end
      DATA: if (tick) begin
        tx_d = bit_q == 3'd7 ? 1'b1 : cur_byte[nb];
        bit_d = nb;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (tick) begin
        if (byte_q < 8'(BYTES_PER_WORD - 1)) begin
          byte_d = byte_q + 8'd1;
          tx_d = 1'b0;
          state_d = START;
        end else begin
          words_sent_d = words_sent_q + 16'd1;
          rd_d = !fifo_empty;
          busy_d = !fifo_empty;
          state_d = fifo_empty ? IDLE : STOP;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs; reset aborts any word in flight with the line idle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      word_q <= '0;
      byte_q <= '0;
      bit_q <= '0;
      tx_q <= 1'b1;
      rd_q <= 1'b0;
      busy_q <= 1'b0;
      words_sent_q <= '0;
    end else begin
      state_q <= state_d;
      word_q <= word_d;
      byte_q <= byte_d;
      bit_q <= bit_d;
      tx_q <= tx_d;
      rd_q <= rd_d;
      busy_q <= busy_d;
      words_sent_q <= words_sent_d;
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed self-checking bench for fifo_uart_tx with a queue-backed FIFO model
module tb_fifo_uart_tx;
  localparam int CPB = 4;
  localparam int LOGN = 8192;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] fifo_data_out = '0;
  logic fifo_empty = 1'b1;
  logic fifo_read_enabled, tx, busy;
  logic [15:0] words_sent;
  int tests = 0;
  int fails = 0;
  int viol = 0;
  int cyc = 0;
  int exp_ws = 0;
  logic [31:0] mem[$];
  logic txl[0:LOGN-1];
  logic rdl[0:LOGN-1];
  logic bl[0:LOGN-1];

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
    .fifo_read_enabled(fifo_read_enabled), .tx(tx), .busy(busy), .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read data, valid the cycle after a pop
  always @(posedge clk)
    if (fifo_read_enabled && mem.size() > 0) begin
      fifo_data_out <= mem.pop_front();
      fifo_empty <= (mem.size() == 0);
    end

  // per-cycle log of DUT outputs, sampled on the falling edge
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      txl[cyc] = tx;
      rdl[cyc] = fifo_read_enabled;
      bl[cyc] = busy;
    end
    if (fifo_read_enabled && fifo_empty) viol++;
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [31:0] w);
    mem.push_back(w);
    fifo_empty = 1'b0;
  endtask

  function automatic int find_pop(input int from);
    for (int i = from; i < cyc && i < LOGN; i++) if (rdl[i]) return i;
    return -1;
  endfunction

  // mid-bit samples of one 10-bit frame starting at cycle s: {stop, data[7:0], start}
  function automatic logic [9:0] frame(input int s);
    logic [9:0] f;
    for (int i = 0; i < 10; i++) f[i] = txl[s + CPB * i + CPB / 2];
    return f;
  endfunction

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #1;
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b want 1", tx); end
    tests++; if (fifo_read_enabled !== 1'b0) begin fails++; $display("FAIL reset_rd: got %b want 0", fifo_read_enabled); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (words_sent !== 16'h0) begin fails++; $display("FAIL reset_ws: got %h want 0000", words_sent); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    int b, p;
    logic [31:0] w;
    w = 32'h000000A5;
    @(negedge clk); #1; b = cyc;
    push(w);
    repeat (190) @(negedge clk);
    #1;
    p = find_pop(b);
    tests++; if (p < 0) begin fails++; $display("FAIL single_pop: got none want one"); return; end
    tests++; if (find_pop(p + 1) != -1) begin fails++; $display("FAIL single_pop_count: extra pop at %0d want none", find_pop(p + 1)); end
    tests++; if (txl[p+2] !== 1'b1 || txl[p+3] !== 1'b0) begin fails++; $display("FAIL single_latency: tx[p+2]=%b tx[p+3]=%b want 1,0", txl[p+2], txl[p+3]); end
    for (int k = 0; k < 4; k++) begin
      tests++; if (frame(p + 3 + 40 * k) !== {1'b1, w[8*k +: 8], 1'b0}) begin fails++; $display("FAIL single_frame%0d: got %b want %b", k, frame(p + 3 + 40 * k), {1'b1, w[8*k +: 8], 1'b0}); end
    end
    tests++; if (bl[p] !== 1'b1 || bl[p+162] !== 1'b1 || bl[p+163] !== 1'b0) begin fails++; $display("FAIL single_busy: pop=%b last=%b after=%b want 1,1,0", bl[p], bl[p+162], bl[p+163]); end
    exp_ws++;
    tests++; if (words_sent !== 16'(exp_ws)) begin fails++; $display("FAIL single_ws: got %0d want %0d", words_sent, exp_ws); end
  endtask

  task automatic test_back_to_back;
    int b, p1, p2, gap;
    logic [63:0] ws;
    ws = {32'h55667788, 32'h11223344};
    @(negedge clk); #1; b = cyc;
    push(ws[31:0]);
    push(ws[63:32]);
    repeat (360) @(negedge clk);
    #1;
    p1 = find_pop(b);
    p2 = p1 < 0 ? -1 : find_pop(p1 + 1);
    tests++; if (p2 < 0) begin fails++; $display("FAIL b2b_pops: got p1=%0d p2=%0d want two pops", p1, p2); return; end
    tests++; if (p2 != p1 + 163) begin fails++; $display("FAIL b2b_spacing: got %0d want 163", p2 - p1); end
    for (int k = 0; k < 8; k++) begin
      tests++; if (frame((k < 4 ? p1 : p2) + 3 + 40 * (k % 4)) !== {1'b1, ws[8*k +: 8], 1'b0}) begin fails++; $display("FAIL b2b_frame%0d: got %b want %b", k, frame((k < 4 ? p1 : p2) + 3 + 40 * (k % 4)), {1'b1, ws[8*k +: 8], 1'b0}); end
    end
    gap = 0;
    for (int i = p1 + 163; i < p2 + 10 && txl[i] === 1'b1; i++) gap++;
    tests++; if (gap != 3) begin fails++; $display("FAIL b2b_gap: got %0d idle cycles want 3", gap); end
    exp_ws += 2;
    tests++; if (words_sent !== 16'(exp_ws)) begin fails++; $display("FAIL b2b_ws: got %0d want %0d", words_sent, exp_ws); end
  endtask

  task automatic test_empty;
    int b, nrd, ntx, nb;
    @(negedge clk); #1; b = cyc;
    repeat (1000) @(negedge clk);
    #1;
    nrd = 0; ntx = 0; nb = 0;
    for (int i = b; i < b + 1000; i++) begin
      if (rdl[i] !== 1'b0) nrd++;
      if (txl[i] !== 1'b1) ntx++;
      if (bl[i] !== 1'b0) nb++;
    end
    tests++; if (nrd != 0) begin fails++; $display("FAIL empty_rd: got %0d pop cycles want 0", nrd); end
    tests++; if (ntx != 0) begin fails++; $display("FAIL empty_tx: got %0d low cycles want 0", ntx); end
    tests++; if (nb != 0) begin fails++; $display("FAIL empty_busy: got %0d busy cycles want 0", nb); end
  endtask

  task automatic test_reset_mid;
    int b;
    bit seen;
    push(32'hDEADBEEF);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = fifo_read_enabled;
    end
    tests++; if (!seen) begin fails++; $display("FAIL mid_pop: got none want one"); return; end
    repeat (92) @(negedge clk);
    #1;
    tests++; if (tx !== 1'b0) begin fails++; $display("FAIL mid_pre_tx: got %b want 0 (byte 2 bit 1)", tx); end
    rst_n = 1'b0;
    #1;
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL mid_abort_tx: got %b want 1", tx); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_abort_busy: got %b want 0", busy); end
    exp_ws = 0;
    tests++; if (words_sent !== 16'h0) begin fails++; $display("FAIL mid_abort_ws: got %0d want 0", words_sent); end
    @(negedge clk);
    rst_n = 1'b1;
    #1; b = cyc;
    repeat (50) @(negedge clk);
    #1;
    tests++; if (find_pop(b) != -1) begin fails++; $display("FAIL mid_no_pop: got pop at %0d want none", find_pop(b)); end
  endtask

  task automatic test_late_push;
    int b, p1, p2, nb;
    bit seen;
    logic [31:0] w2;
    w2 = 32'hCAFEF00D;
    @(negedge clk); #1; b = cyc;
    push(32'h12345678);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = fifo_read_enabled;
    end
    tests++; if (!seen) begin fails++; $display("FAIL late_pop1: got none want one"); return; end
    repeat (160) @(negedge clk);
    #1;
    push(w2);
    repeat (200) @(negedge clk);
    #1;
    p1 = find_pop(b);
    p2 = p1 < 0 ? -1 : find_pop(p1 + 1);
    tests++; if (p2 != p1 + 163) begin fails++; $display("FAIL late_pop2: got offset %0d want 163", p2 - p1); return; end
    nb = 0;
    for (int i = p1; i <= p2; i++) if (bl[i] !== 1'b1) nb++;
    tests++; if (nb != 0) begin fails++; $display("FAIL late_no_idle: got %0d idle cycles want 0", nb); end
    tests++; if (frame(p2 + 3) !== {1'b1, w2[7:0], 1'b0}) begin fails++; $display("FAIL late_frame0: got %b want %b", frame(p2 + 3), {1'b1, w2[7:0], 1'b0}); end
    tests++; if (frame(p2 + 123) !== {1'b1, w2[31:24], 1'b0}) begin fails++; $display("FAIL late_frame3: got %b want %b", frame(p2 + 123), {1'b1, w2[31:24], 1'b0}); end
    exp_ws += 2;
    tests++; if (words_sent !== 16'(exp_ws)) begin fails++; $display("FAIL late_ws: got %0d want %0d", words_sent, exp_ws); end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    force dut.words_sent_q = 16'hFFFF;
    @(negedge clk);
    release dut.words_sent_q;
    @(negedge clk);
    #1;
    tests++; if (words_sent !== 16'hFFFF) begin fails++; $display("FAIL wrap_pre: got %h want ffff", words_sent); end
    push(32'h0000003C);
    repeat (190) @(negedge clk);
    #1;
    tests++; if (words_sent !== 16'h0000) begin fails++; $display("FAIL wrap_ws: got %h want 0000", words_sent); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL wrap_busy: got %b want 0", busy); end
  endtask

  task automatic test_protocol;
    tests++; if (viol != 0) begin fails++; $display("FAIL pop_while_empty: got %0d want 0", viol); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_empty;
    test_reset_mid;
    test_late_push;
    test_wrap;
    test_protocol;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per UART bit period; legal values are 2 and above.
REQ-002 Parameter BYTES_PER_WORD, default `DATA_WIDTH/8, number of bytes serialized from each FIFO word.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 fifo_data_out  input  `DATA_WIDTH  FIFO read data, valid one cycle after a read pulse.
REQ-006 fifo_empty  input  1  FIFO holds no words.
REQ-007 fifo_read_enabled  output  1  one-cycle pop request to the FIFO.
REQ-008 tx  output  1  UART serial line, 8N1 format, idle high.
REQ-009 busy  output  1  high from the pop cycle until the last stop bit completes.
REQ-010 words_sent  output  16  count of fully transmitted words, wraps from 0xFFFF to 0.

Function
REQ-011 `DATA_WIDTH shall be a multiple of 8; elaboration shall fail otherwise.
REQ-012 The FSM shall have states IDLE, FETCH, LOAD, START, DATA and STOP.
REQ-013 IDLE with fifo_empty=0: the block shall assert fifo_read_enabled for exactly one cycle and enter FETCH.
REQ-014 FETCH shall last one cycle, and fifo_read_enabled shall be 0 in FETCH.
REQ-015 LOAD shall capture fifo_data_out into the word register, set the byte index to 0, and enter START.
REQ-016 START, each DATA bit and STOP shall each hold tx for exactly CLKS_PER_BIT cycles, timed by a bit-period counter that reloads on every state or bit change.
REQ-017 START shall drive tx=0; DATA shall drive bits 0..7 of the current byte, LSB first; STOP shall drive tx=1.
REQ-018 Bytes shall be taken from the word LSB byte first: byte k = word[8k+7:8k].
REQ-019 At the end of STOP, if the byte index is below BYTES_PER_WORD-1, the block shall increment the index and enter START with no idle gap.
REQ-020 At the end of STOP on the last byte, the block shall increment words_sent.
REQ-021 After that last byte, the block shall pulse fifo_read_enabled and enter FETCH if fifo_empty=0, and shall otherwise enter IDLE.
REQ-022 fifo_read_enabled shall never be asserted while fifo_empty=1.
REQ-023 fifo_read_enabled shall never be asserted outside the two pop points defined in REQ-013 and REQ-021.
REQ-024 A change on fifo_empty during a word shall have no effect until the end of the last STOP of that word.
REQ-025 First start bit latency: the start bit shall begin 3 cycles after the pop cycle (pop, FETCH, LOAD, then START).
REQ-026 Word duration shall be 10*CLKS_PER_BIT*BYTES_PER_WORD cycles from the first start bit to the end of the last stop bit.
REQ-027 busy shall equal (state != IDLE) and shall also be high in the pop cycle.
REQ-028 tx shall be glitch-free; it shall be driven from a flop, not from combinational decode.

Reset
REQ-029 While rst_n=0: state=IDLE, tx=1, fifo_read_enabled=0, busy=0, words_sent=0, bit counter, byte index and word register all 0.
REQ-030 Reset asserted mid-word shall abort immediately with tx=1; the partial word shall be lost and shall not be counted.
REQ-031 After rst_n deasserts, the first pop shall occur no earlier than the first rising edge of clk that sees rst_n=1.

Structure
REQ-032 A shared package leg_uart_pkg shall hold the tx_state_t enum, the UART_FRAME_BITS=10 constant, and the CLKS_PER_BIT default.
REQ-033 A sub-module uart_baud_gen shall hold the bit-period down-counter, with inputs reload and enable and a one-cycle tick output.
REQ-034 Each instance shall connect to the FIFO read side of the FIFO that memmap writes at address 0xFFFFFFFF.

Verification (bench: `DATA_WIDTH=32, CLKS_PER_BIT=4)
REQ-035 Single word: push 0x000000A5 -> one pop pulse; tx shows frames A5,00,00,00 LSB first, each 40 cycles; start bit 3 cycles after the pop; words_sent=1; busy falls after 160 cycles of frames.
REQ-036 Back-to-back: preload 0x11223344 and 0x55667788 -> bytes 44,33,22,11,88,77,66,55; exactly 3 cycles of tx=1 between the words; words_sent=2.
REQ-037 Empty FIFO held for 1000 cycles -> fifo_read_enabled stays 0, tx stays 1, busy stays 0.
REQ-038 Reset mid-word: assert rst_n=0 during byte 2 of 0xDEADBEEF -> tx=1 in the same cycle; words_sent=0; after release with an empty FIFO, no further pops.
REQ-039 Late push: push a word while the last STOP of the previous word is in progress -> second pop occurs in the cycle the STOP ends, with no IDLE cycle.
REQ-040 Wrap: force words_sent to 0xFFFF and send one word -> words_sent=0x0000.
